// File: rtl/sprite_blitter.sv
// Sprite blitter: scans a SPR_W x SPR_H sprite from a synchronous memory and
// emits clipped, optionally mirrored and colour-keyed pixel writes at an origin.
module sprite_blitter #(
    parameter int WIDTH_X   = 9,
    parameter int WIDTH_Y   = 9,
    parameter int SPR_W     = 32,
    parameter int SPR_H     = 24,
    parameter int SCRN_W    = 320,
    parameter int SCRN_H    = 240,
    parameter int ADDR_W    = 10,
    parameter int COLOR_W   = 3,
    parameter int TRANSP_EN = 1,
    parameter int KEY_COLOR = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH_X-1:0] org_x,
    input  logic [WIDTH_Y-1:0] org_y,
    input  logic               flip_x,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               plot,
    output logic [WIDTH_X-1:0] x,
    output logic [WIDTH_Y-1:0] y,
    output logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done
);

    localparam int CX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int CY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int PX_W = WIDTH_X + 1;
    localparam int PY_W = WIDTH_Y + 1;

    localparam logic [CX_W-1:0]    CX_LAST    = CX_W'(SPR_W - 1);
    localparam logic [CY_W-1:0]    CY_LAST    = CY_W'(SPR_H - 1);
    localparam logic [PX_W-1:0]    SCRN_W_LIM = PX_W'(SCRN_W);
    localparam logic [PY_W-1:0]    SCRN_H_LIM = PY_W'(SCRN_H);
    localparam logic [COLOR_W-1:0] KEY        = COLOR_W'(KEY_COLOR);
    localparam logic [ADDR_W-1:0]  ROW_STRIDE = ADDR_W'(SPR_W);

    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CX_W-1:0]    cx_reg;
    logic [CY_W-1:0]    cy_reg;
    logic [WIDTH_X-1:0] org_x_reg;
    logic [WIDTH_Y-1:0] org_y_reg;
    logic               flip_reg;
    logic               valid_reg;
    logic [PX_W-1:0]    px_reg;
    logic [PY_W-1:0]    py_reg;
    logic               scan_last;
    logic [CX_W-1:0]    col;
    logic               key_hit;

    assign scan_last = (cx_reg == CX_LAST) && (cy_reg == CY_LAST);
    assign col       = flip_reg ? (CX_LAST - cx_reg) : cx_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        rom_addr   = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                busy     = 1'b1;
                rom_addr = ADDR_W'(cy_reg) * ROW_STRIDE + ADDR_W'(col);
                if (abort) begin
                    state_next = IDLE;
                end else if (scan_last) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                busy       = 1'b1;
                state_next = abort ? IDLE : DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counters, latched blit parameters and the one-deep pixel pipeline that
    // lines coordinates up with the memory's one-cycle read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx_reg    <= '0;
            cy_reg    <= '0;
            org_x_reg <= '0;
            org_y_reg <= '0;
            flip_reg  <= 1'b0;
            valid_reg <= 1'b0;
            px_reg    <= '0;
            py_reg    <= '0;
        end else begin
            valid_reg <= (state_reg == SCAN) && !abort;
            if (state_reg == SCAN) begin
                px_reg <= {1'b0, org_x_reg} + PX_W'(cx_reg);
                py_reg <= {1'b0, org_y_reg} + PY_W'(cy_reg);
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        org_x_reg <= org_x;
                        org_y_reg <= org_y;
                        flip_reg  <= flip_x;
                        cx_reg    <= '0;
                        cy_reg    <= '0;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        cx_reg <= '0;
                        cy_reg <= '0;
                    end else if (cx_reg == CX_LAST) begin
                        cx_reg <= '0;
                        cy_reg <= (cy_reg == CY_LAST) ? '0 : cy_reg + CY_W'(1);
                    end else begin
                        cx_reg <= cx_reg + CX_W'(1);
                    end
                end
                default: begin
                    cx_reg <= '0;
                    cy_reg <= '0;
                end
            endcase
        end
    end

    // Extra coordinate bit keeps off-screen pixels from wrapping back into view.
    assign key_hit = (TRANSP_EN != 0) && (rom_data == KEY);
    assign plot    = valid_reg && (px_reg < SCRN_W_LIM) && (py_reg < SCRN_H_LIM) && !key_hit;
    assign x       = valid_reg ? px_reg[WIDTH_X-1:0] : '0;
    assign y       = valid_reg ? py_reg[WIDTH_Y-1:0] : '0;
    assign color   = valid_reg ? rom_data : '0;

endmodule
